data_mem_responder: RTL and testbench
=====================================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024: number of 32-bit storage words (power of two).
REQ-002 SHALL have parameter BASE_ADDR, default 32'h8000_0000: byte address of word 0.
REQ-003 SHALL have parameter LATENCY, default 1: cycles from request accept to rsp_valid (legal range 1..15).
REQ-004 SHALL have one clock and an asynchronous, active-low reset.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 req_valid  in  1  initiator presents a request.
REQ-008 req_ready  out  1  responder accepts a request this cycle.
REQ-009 req_addr  in  32  byte address.
REQ-010 req_wdata  in  32  store data, right-aligned.
REQ-011 req_wr  in  1  1 = store, 0 = load.
REQ-012 req_memop  in  3  RISC-V funct3 size code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-013 rsp_valid  out  1  response is present.
REQ-014 rsp_ready  in  1  initiator takes the response.
REQ-015 rsp_rdata  out  32  load data, extended to 32 bits; 0 for stores and errors.
REQ-016 rsp_err  out  1  request was misaligned, out of range or used an illegal memop.

Function
REQ-017 SHALL implement FSM IDLE -> WAIT -> RESP -> IDLE, with one outstanding request at most.
REQ-018 req_ready SHALL be 1 only in IDLE; a request is accepted on a rising edge when req_valid && req_ready.
REQ-019 On accept, the block SHALL capture address, data, op and size, and load the latency counter with LATENCY-1.
- LATENCY==1: go directly to RESP.
- Otherwise: go to WAIT.
REQ-020 WAIT SHALL decrement the counter each cycle and enter RESP on the edge where the counter is 0, giving rsp_valid exactly LATENCY cycles after the accept edge.
REQ-021 In RESP, rsp_valid SHALL be 1; rsp_rdata and rsp_err SHALL stay stable until rsp_valid && rsp_ready, after which the FSM returns to IDLE.
REQ-022 A new request SHALL NOT be accepted in the same cycle as the response handshake; the earliest next accept is the following cycle.
REQ-023 Word index SHALL be (req_addr - BASE_ADDR) >> 2; the address is in range iff (req_addr - BASE_ADDR) < 4*DEPTH_WORDS, computed unsigned with 32-bit wrap-around.
REQ-024 Alignment: H/HU SHALL need addr[0]==0; W SHALL need addr[1:0]==0; B/BU have no alignment requirement.
REQ-025 A misaligned, out-of-range, or illegal memop request (011/110/111; for stores, anything other than 000/001/010) SHALL give rsp_err=1 and rsp_rdata=0, and SHALL NOT modify storage.
REQ-026 A legal store SHALL write on the accept edge, byte-enabled by addr[1:0] and size:
- SB: lane addr[1:0] gets wdata[7:0].
- SH: lanes {addr[1],0}+1..0 get wdata[15:0].
- SW: all four lanes.
- Other lanes are unchanged.
REQ-027 A legal load SHALL read the word on the accept edge, select the lane(s) by addr[1:0], then:
- B/H: sign-extend.
- BU/HU: zero-extend.
- W: pass through.
REQ-028 Store followed by load to the same address SHALL return the stored data, with no hazard window.
REQ-029 Storage contents SHALL be unaffected by reset and undefined before the first write.

Reset
REQ-030 When rst_n is low, the block SHALL immediately go to IDLE, with req_ready=1 after release, and rsp_valid=0, rsp_rdata=0, rsp_err=0, counter=0.
REQ-031 Reset during WAIT or RESP SHALL discard the pending response.
- A store already committed at accept SHALL remain in storage.
REQ-032 The first accept after reset SHALL be possible on the first rising edge with rst_n high.

Verification
REQ-033 LATENCY=1: SW 0x8000_0000 <- 0xDEAD_BEEF, then LW 0x8000_0000.
- Each rsp_valid 1 cycle after its accept.
- Load rdata = 0xDEADBEEF, err = 0.
REQ-034 After REQ-033: SB 0x8000_0001 <- 0x80, then:
- LB 0x8000_0001 -> 0xFFFF_FF80.
- LBU -> 0x0000_0080.
- LW -> 0xDEAD_80EF.
REQ-035 Errors, each with rsp_err=1, rdata=0 and storage unchanged:
- LH 0x8000_0003.
- SW 0x8000_0002.
- LW 0x7FFF_FFFC.
- LW BASE+4*DEPTH_WORDS.
REQ-036 LATENCY=4 with rsp_ready held 0 for 3 cycles:
- rsp_valid rises 4 cycles after accept.
- Outputs are stable while stalled.
- req_ready stays 0 until the cycle after the handshake.
REQ-037 LATENCY=4: assert rst_n=0 two cycles after an SW accept.
- rsp_valid = 0 immediately.
- req_ready = 1 after release.
- A subsequent LW returns the stored word.

Source files
------------

// File: rtl/data_mem_responder_if.sv
// Request/response bus between an initiator (master) and the data memory
// responder (slave): one request channel and one response channel, each
// with its own valid/ready handshake.
interface data_mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_wr;
  logic [2:0]  req_memop;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_addr, req_wdata, req_wr, req_memop, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, req_wdata, req_wr, req_memop, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_mem_responder.sv
// Single-outstanding data memory responder. Loads and stores are resolved
// on the accept edge. The response, which is load data or an error flag, is
// held in registers. It is presented LATENCY cycles later and stays until the
// initiator takes it.
module data_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int unsigned LATENCY     = 1
) (
  input logic                 clk,
  input logic                 rst_n,
  data_mem_responder_if.slave bus
);

  localparam int unsigned AW         = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN_BYTES = 33'(DEPTH_WORDS) << 2;
  localparam logic [3:0]  LAT_LOAD   = 4'(LATENCY - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] mem [DEPTH_WORDS];

  logic [31:0]   offset;
  logic [AW-1:0] word_idx;
  logic          in_range;
  logic          op_legal;
  logic          aligned;
  logic          req_err;
  logic [31:0]   rd_word;
  logic [7:0]    rd_byte;
  logic [15:0]   rd_half;
  logic [31:0]   load_val;
  logic [3:0]    byte_en;
  logic [31:0]   store_lanes;
  logic          do_store;

  // Decode the presented request: range, legality, alignment, load data and store lanes
  always_comb begin
    offset   = bus.req_addr - BASE_ADDR;
    in_range = {1'b0, offset} < SPAN_BYTES;
    word_idx = offset[AW+1:2];
    rd_word  = mem[word_idx];
    rd_byte  = rd_word[{bus.req_addr[1:0], 3'b000} +: 8];
    rd_half  = rd_word[{bus.req_addr[1], 4'b0000} +: 16];

    if (bus.req_wr)
      op_legal = (bus.req_memop == 3'b000) || (bus.req_memop == 3'b001) ||
                 (bus.req_memop == 3'b010);
    else
      op_legal = (bus.req_memop == 3'b000) || (bus.req_memop == 3'b001) ||
                 (bus.req_memop == 3'b010) || (bus.req_memop == 3'b100) ||
                 (bus.req_memop == 3'b101);

    case (bus.req_memop[1:0])
      2'b01:   aligned = !bus.req_addr[0];
      2'b10:   aligned = (bus.req_addr[1:0] == 2'b00);
      default: aligned = 1'b1;
    endcase

    req_err = !(in_range && op_legal && aligned);

    case (bus.req_memop)
      3'b000:  load_val = {{24{rd_byte[7]}}, rd_byte};
      3'b001:  load_val = {{16{rd_half[15]}}, rd_half};
      3'b010:  load_val = rd_word;
      3'b100:  load_val = {24'd0, rd_byte};
      3'b101:  load_val = {16'd0, rd_half};
      default: load_val = 32'd0;
    endcase

    case (bus.req_memop[1:0])
      2'b00: begin
        byte_en     = 4'b0001 << bus.req_addr[1:0];
        store_lanes = {4{bus.req_wdata[7:0]}};
      end
      2'b01: begin
        byte_en     = 4'b0011 << {bus.req_addr[1], 1'b0};
        store_lanes = {2{bus.req_wdata[15:0]}};
      end
      default: begin
        byte_en     = 4'b1111;
        store_lanes = bus.req_wdata;
      end
    endcase

    do_store = (state_q == ST_IDLE) && bus.req_valid && bus.req_wr && !req_err;
  end

  // Storage is deliberately not reset; a legal store commits on its accept edge
  always_ff @(posedge clk) begin
    if (do_store) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) mem[word_idx][8*b +: 8] <= store_lanes[8*b +: 8];
      end
    end
  end

  // Next-state logic: the counter is loaded with LATENCY-1 at accept, and RESP is entered on the edge where it reaches zero
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          rdata_d = (req_err || bus.req_wr) ? 32'd0 : load_val;
          err_d   = req_err;
          cnt_d   = LAT_LOAD;
          state_d = (LATENCY == 1) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          rdata_d = 32'd0;
          err_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, counter and response registers; reset drops any pending response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign bus.req_ready = (state_q == ST_IDLE);
  assign bus.rsp_valid = (state_q == ST_RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder. Instance A uses LATENCY=1 and instance B
// uses LATENCY=4. Each instance has its own reset. Expected responses are
// queued when a request is issued. One monitor per instance pops an entry
// and compares it on every response handshake.
module tb_data_mem_responder;
  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          DEPTH = 1024;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n_a;
  logic rst_n_b;

  int checks = 0;
  int errors = 0;
  int last_wait;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t mon_a_e;
  exp_t mon_b_e;

  data_mem_responder_if if_a ();
  data_mem_responder_if if_b ();

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .LATENCY(1)) dut_a (
    .clk(clk), .rst_n(rst_n_a), .bus(if_a)
  );

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .LATENCY(4)) dut_b (
    .clk(clk), .rst_n(rst_n_b), .bus(if_b)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Safety net so the run always ends
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic drive_req(input int inst, input logic valid, input logic wr, input logic [2:0] op,
                           input logic [31:0] addr, input logic [31:0] wdata);
    if (inst == 0) begin
      if_a.req_valid = valid; if_a.req_wr = wr; if_a.req_memop = op;
      if_a.req_addr = addr; if_a.req_wdata = wdata;
    end else begin
      if_b.req_valid = valid; if_b.req_wr = wr; if_b.req_memop = op;
      if_b.req_addr = addr; if_b.req_wdata = wdata;
    end
  endtask

  task automatic set_rsp_ready(input int inst, input logic v);
    if (inst == 0) if_a.rsp_ready = v;
    else           if_b.rsp_ready = v;
  endtask

  function automatic logic get_req_ready(input int inst);
    return (inst == 0) ? if_a.req_ready : if_b.req_ready;
  endfunction

  function automatic logic get_rsp_valid(input int inst);
    return (inst == 0) ? if_a.rsp_valid : if_b.rsp_valid;
  endfunction

  function automatic logic [31:0] get_rdata(input int inst);
    return (inst == 0) ? if_a.rsp_rdata : if_b.rsp_rdata;
  endfunction

  function automatic logic get_err(input int inst);
    return (inst == 0) ? if_a.rsp_err : if_b.rsp_err;
  endfunction

  // Scoreboard monitor for instance A: compare on each response handshake
  always @(negedge clk) begin
    if (if_a.rsp_valid === 1'b1 && if_a.rsp_ready === 1'b1) begin
      if (q_a.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL dut_a unexpected response: got 0x%08h expected none", if_a.rsp_rdata);
      end else begin
        mon_a_e = q_a.pop_front();
        checkOutput("dut_a rsp_rdata", if_a.rsp_rdata, mon_a_e.rdata);
        checkOutput("dut_a rsp_err", 32'(if_a.rsp_err), 32'(mon_a_e.err));
      end
    end
  end

  // Scoreboard monitor for instance B: compare on each response handshake
  always @(negedge clk) begin
    if (if_b.rsp_valid === 1'b1 && if_b.rsp_ready === 1'b1) begin
      if (q_b.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL dut_b unexpected response: got 0x%08h expected none", if_b.rsp_rdata);
      end else begin
        mon_b_e = q_b.pop_front();
        checkOutput("dut_b rsp_rdata", if_b.rsp_rdata, mon_b_e.rdata);
        checkOutput("dut_b rsp_err", 32'(if_b.rsp_err), 32'(mon_b_e.err));
      end
    end
  end

  // Issue one request, queue its expected response, and follow it through latency, stall and handshake
  task automatic applyStimulus(input int inst, input string name, input logic wr, input logic [2:0] op,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] exp_rdata, input logic exp_err,
                               input int exp_lat, input int stall);
    exp_t e;
    int   n;
    bit   ok;
    e.rdata = exp_rdata;
    e.err   = exp_err;
    if (inst == 0) q_a.push_back(e);
    else           q_b.push_back(e);
    if (stall > 0) set_rsp_ready(inst, 1'b0);
    drive_req(inst, 1'b1, wr, op, addr, wdata);

    last_wait = 0;
    ok = 1'b0;
    while (!ok) begin
      @(negedge clk);
      if (get_req_ready(inst) === 1'b1) ok = 1'b1;
      else begin
        last_wait++;
        if (last_wait > 50) break;
        @(posedge clk); #1;
      end
    end
    if (!ok) begin
      checkOutput({name, " accept timeout"}, 32'd0, 32'd1);
      drive_req(inst, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
      set_rsp_ready(inst, 1'b1);
      return;
    end
    @(posedge clk); #1;
    drive_req(inst, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0);

    n = 0;
    ok = 1'b0;
    while (n < 64) begin
      @(negedge clk);
      n++;
      if (get_rsp_valid(inst) === 1'b1) begin
        ok = 1'b1;
        break;
      end
      checkOutput({name, " req_ready while busy"}, 32'(get_req_ready(inst)), 32'd0);
      @(posedge clk); #1;
    end
    checkOutput({name, " latency"}, 32'(n), 32'(exp_lat));
    if (!ok) begin
      set_rsp_ready(inst, 1'b1);
      return;
    end

    for (int i = 0; i < stall; i++) begin
      checkOutput({name, " stall rsp_valid"}, 32'(get_rsp_valid(inst)), 32'd1);
      checkOutput({name, " stall rsp_rdata"}, get_rdata(inst), exp_rdata);
      checkOutput({name, " stall rsp_err"}, 32'(get_err(inst)), 32'(exp_err));
      checkOutput({name, " stall req_ready"}, 32'(get_req_ready(inst)), 32'd0);
      @(posedge clk); #1;
      if (i == stall - 1) set_rsp_ready(inst, 1'b1);
      @(negedge clk);
    end

    checkOutput({name, " req_ready in handshake cycle"}, 32'(get_req_ready(inst)), 32'd0);
    @(posedge clk); #1;
    checkOutput({name, " rsp_valid after handshake"}, 32'(get_rsp_valid(inst)), 32'd0);
    checkOutput({name, " req_ready after handshake"}, 32'(get_req_ready(inst)), 32'd1);
  endtask

  // Directed sequence
  initial begin
    rst_n_a = 1'b0;
    rst_n_b = 1'b0;
    drive_req(0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
    drive_req(1, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
    set_rsp_ready(0, 1'b1);
    set_rsp_ready(1, 1'b1);

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset a rsp_valid", 32'(if_a.rsp_valid), 32'd0);
    checkOutput("reset a rsp_rdata", if_a.rsp_rdata, 32'd0);
    checkOutput("reset a rsp_err", 32'(if_a.rsp_err), 32'd0);
    checkOutput("reset b rsp_valid", 32'(if_b.rsp_valid), 32'd0);
    checkOutput("reset b rsp_rdata", if_b.rsp_rdata, 32'd0);
    checkOutput("reset b rsp_err", 32'(if_b.rsp_err), 32'd0);
    rst_n_a = 1'b1;
    rst_n_b = 1'b1;
    #1;
    checkOutput("reset a req_ready", 32'(if_a.req_ready), 32'd1);
    checkOutput("reset b req_ready", 32'(if_b.req_ready), 32'd1);

    // LATENCY=1: basic word/byte traffic
    applyStimulus(0, "SW base", 1'b1, 3'b010, BASE, 32'hDEAD_BEEF, 32'd0, 1'b0, 1, 0);
    checkOutput("first accept wait", 32'(last_wait), 32'd0);
    applyStimulus(0, "LW base", 1'b0, 3'b010, BASE, 32'd0, 32'hDEAD_BEEF, 1'b0, 1, 0);
    applyStimulus(0, "SB +1", 1'b1, 3'b000, BASE + 32'd1, 32'hAAAA_AA80, 32'd0, 1'b0, 1, 0);
    applyStimulus(0, "LB +1", 1'b0, 3'b000, BASE + 32'd1, 32'd0, 32'hFFFF_FF80, 1'b0, 1, 0);
    applyStimulus(0, "LBU +1", 1'b0, 3'b100, BASE + 32'd1, 32'd0, 32'h0000_0080, 1'b0, 1, 0);
    applyStimulus(0, "LW after SB", 1'b0, 3'b010, BASE, 32'd0, 32'hDEAD_80EF, 1'b0, 1, 0);
    applyStimulus(0, "LH +2", 1'b0, 3'b001, BASE + 32'd2, 32'd0, 32'hFFFF_DEAD, 1'b0, 1, 0);
    applyStimulus(0, "LHU +0", 1'b0, 3'b101, BASE, 32'd0, 32'h0000_80EF, 1'b0, 1, 0);
    applyStimulus(0, "LB +0", 1'b0, 3'b000, BASE, 32'd0, 32'hFFFF_FFEF, 1'b0, 1, 0);
    applyStimulus(0, "LBU +3", 1'b0, 3'b100, BASE + 32'd3, 32'd0, 32'h0000_00DE, 1'b0, 1, 0);
    applyStimulus(0, "SH +6", 1'b1, 3'b001, BASE + 32'd6, 32'hBBBB_1234, 32'd0, 1'b0, 1, 0);
    applyStimulus(0, "LHU +6", 1'b0, 3'b101, BASE + 32'd6, 32'd0, 32'h0000_1234, 1'b0, 1, 0);

    // Error cases leave storage untouched
    applyStimulus(0, "LH misaligned", 1'b0, 3'b001, BASE + 32'd3, 32'd0, 32'd0, 1'b1, 1, 0);
    applyStimulus(0, "SW misaligned", 1'b1, 3'b010, BASE + 32'd2, 32'hFFFF_FFFF, 32'd0, 1'b1, 1, 0);
    applyStimulus(0, "LW below base", 1'b0, 3'b010, 32'h7FFF_FFFC, 32'd0, 32'd0, 1'b1, 1, 0);
    applyStimulus(0, "LW past end", 1'b0, 3'b010, BASE + 32'h0000_1000, 32'd0, 32'd0, 1'b1, 1, 0);
    applyStimulus(0, "LW op 011", 1'b0, 3'b011, BASE, 32'd0, 32'd0, 1'b1, 1, 0);
    applyStimulus(0, "store op 100", 1'b1, 3'b100, BASE, 32'h1111_1111, 32'd0, 1'b1, 1, 0);
    applyStimulus(0, "LW unchanged", 1'b0, 3'b010, BASE, 32'd0, 32'hDEAD_80EF, 1'b0, 1, 0);
    applyStimulus(0, "SW last word", 1'b1, 3'b010, BASE + 32'h0000_0FFC, 32'h0BAD_F00D, 32'd0, 1'b0, 1, 0);
    applyStimulus(0, "LW last word", 1'b0, 3'b010, BASE + 32'h0000_0FFC, 32'd0, 32'h0BAD_F00D, 1'b0, 1, 0);

    // LATENCY=4 with a three-cycle response stall
    applyStimulus(1, "L4 SW", 1'b1, 3'b010, BASE + 32'h10, 32'hCAFE_F00D, 32'd0, 1'b0, 4, 0);
    applyStimulus(1, "L4 LW stall", 1'b0, 3'b010, BASE + 32'h10, 32'd0, 32'hCAFE_F00D, 1'b0, 4, 3);

    // LATENCY=4 reset two cycles after a store accept; the store must survive
    drive_req(1, 1'b1, 1'b1, 3'b010, BASE + 32'h20, 32'h5A5A_1234);
    @(negedge clk);
    checkOutput("rst test req_ready before accept", 32'(if_b.req_ready), 32'd1);
    @(posedge clk); #1;
    drive_req(1, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
    @(posedge clk);
    @(posedge clk); #1;
    rst_n_b = 1'b0;
    #1;
    checkOutput("rst test rsp_valid", 32'(if_b.rsp_valid), 32'd0);
    checkOutput("rst test req_ready in reset", 32'(if_b.req_ready), 32'd1);
    checkOutput("rst test rsp_rdata", if_b.rsp_rdata, 32'd0);
    checkOutput("rst test rsp_err", 32'(if_b.rsp_err), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst test rsp_valid held", 32'(if_b.rsp_valid), 32'd0);
    rst_n_b = 1'b1;
    #1;
    checkOutput("rst test req_ready after release", 32'(if_b.req_ready), 32'd1);
    applyStimulus(1, "L4 LW after reset", 1'b0, 3'b010, BASE + 32'h20, 32'd0, 32'h5A5A_1234, 1'b0, 4, 0);
    checkOutput("rst test first accept wait", 32'(last_wait), 32'd0);

    repeat (3) @(posedge clk);
    #1;
    checkOutput("queue a drained", 32'(q_a.size()), 32'd0);
    checkOutput("queue b drained", 32'(q_b.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
